// File: rtl/decode_ctrl_seq.sv
// Decode-stage control unit with D/E pipeline register and mul/div occupancy FSM.
// Optional RV32M decode and multi-cycle sequencing enabled by macro RV32M_EN.
module decode_ctrl_seq #(
  parameter int ALU_CTRL_W  = 5,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid_d,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  funct7b0,
  input  logic                  stall_e,
  input  logic                  flush_e,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic                  busy_stall_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  jump_e,
  output logic                  branch_e,
  output logic                  alu_src_a_e,
  output logic                  alu_src_b_e,
  output logic                  adder_src_e,
  output logic [1:0]            res_src_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  md_start_e,
  output logic                  md_done_e
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic       reg_write_s, mem_write_s, jump_s, branch_s;
  logic       alu_src_a_s, alu_src_b_s, adder_src_s, known_s, md_s, load_ok_s;
  logic [1:0] res_src_s;
  logic [2:0] imm_s;
  logic [4:0] alu_code_s;

  function automatic logic [4:0] alu_arith(input logic [2:0] f3, input logic sub, input logic sra);
    logic [4:0] code;
    case (f3)
      3'b000:  code = sub ? 5'd1 : 5'd0;
      3'b001:  code = 5'd2;
      3'b010:  code = 5'd3;
      3'b011:  code = 5'd4;
      3'b100:  code = 5'd5;
      3'b101:  code = sra ? 5'd7 : 5'd6;
      3'b110:  code = 5'd8;
      3'b111:  code = 5'd9;
      default: code = 5'd0;
    endcase
    return code;
  endfunction

  // Combinational decode of the instruction in the D slot
  always_comb begin
    reg_write_s = 1'b0; mem_write_s = 1'b0; jump_s = 1'b0; branch_s = 1'b0;
    alu_src_a_s = 1'b0; alu_src_b_s = 1'b0; adder_src_s = 1'b0;
    res_src_s = 2'b00; imm_s = 3'b000; alu_code_s = 5'd0; md_s = 1'b0; known_s = 1'b1;
    case (op)
      7'b0000011: begin reg_write_s = 1'b1; alu_src_b_s = 1'b1; res_src_s = 2'b01; end
      7'b0100011: begin mem_write_s = 1'b1; alu_src_b_s = 1'b1; imm_s = 3'b001; end
      7'b0010011: begin
        reg_write_s = 1'b1; alu_src_b_s = 1'b1;
        alu_code_s = alu_arith(funct3, op[5] & funct7b5, funct7b5);
      end
      7'b0110011: begin
        reg_write_s = 1'b1;
`ifdef RV32M_EN
        if (funct7b0) begin
          alu_code_s = 5'd14 + {2'b00, funct3};
          md_s = 1'b1;
        end else begin
          alu_code_s = alu_arith(funct3, op[5] & funct7b5, funct7b5);
        end
`else
        alu_code_s = alu_arith(funct3, op[5] & funct7b5, funct7b5);
`endif
      end
      7'b1100011: begin
        branch_s = 1'b1; imm_s = 3'b010;
        case (funct3[2:1])
          2'b00:   alu_code_s = 5'd10;
          2'b10:   alu_code_s = 5'd11;
          2'b11:   alu_code_s = 5'd12;
          default: alu_code_s = 5'd0;
        endcase
      end
      7'b1101111: begin reg_write_s = 1'b1; jump_s = 1'b1; res_src_s = 2'b10; imm_s = 3'b011; end
      7'b1100111: begin reg_write_s = 1'b1; jump_s = 1'b1; res_src_s = 2'b10; adder_src_s = 1'b1; end
      7'b0110111: begin reg_write_s = 1'b1; alu_src_b_s = 1'b1; imm_s = 3'b100; alu_code_s = 5'd13; end
      7'b0010111: begin
        reg_write_s = 1'b1; alu_src_a_s = 1'b1; alu_src_b_s = 1'b1; imm_s = 3'b100;
      end
      default:    known_s = 1'b0;
    endcase
  end

  assign imm_src_d = imm_s;
  assign illegal_d = instr_valid_d & ~known_s;
  assign load_ok_s = instr_valid_d & known_s;

  logic md_e_r, div_e_r;

  // D/E pipeline register: flush beats any stall, invalid slots load zeros
  always_ff @(posedge clk) begin
    if (rst | flush_e) begin
      valid_e <= 1'b0; reg_write_e <= 1'b0; mem_write_e <= 1'b0; jump_e <= 1'b0;
      branch_e <= 1'b0; alu_src_a_e <= 1'b0; alu_src_b_e <= 1'b0; adder_src_e <= 1'b0;
      res_src_e <= 2'b00; alu_control_e <= '0; md_e_r <= 1'b0; div_e_r <= 1'b0;
    end else if (stall_e | busy_stall_d) begin
      valid_e <= valid_e;
    end else begin
      valid_e       <= load_ok_s;
      reg_write_e   <= reg_write_s & load_ok_s;
      mem_write_e   <= mem_write_s & load_ok_s;
      jump_e        <= jump_s & load_ok_s;
      branch_e      <= branch_s & load_ok_s;
      alu_src_a_e   <= alu_src_a_s & load_ok_s;
      alu_src_b_e   <= alu_src_b_s & load_ok_s;
      adder_src_e   <= adder_src_s & load_ok_s;
      res_src_e     <= res_src_s & {2{load_ok_s}};
      alu_control_e <= load_ok_s ? ALU_CTRL_W'(alu_code_s) : '0;
      md_e_r        <= md_s & load_ok_s;
      div_e_r       <= funct3[2] & load_ok_s;
    end
  end

`ifdef RV32M_EN
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r, lat_m2_s;
  logic             lat_gt1_s, md_act_s;

  assign md_act_s = valid_e & md_e_r;

  // Latency of the op class currently in E
  always_comb begin
    if (div_e_r) begin
      lat_gt1_s = (DIV_LATENCY > 1);
      lat_m2_s  = CNT_W'(DIV_LATENCY - 2);
    end else begin
      lat_gt1_s = (MUL_LATENCY > 1);
      lat_m2_s  = CNT_W'(MUL_LATENCY - 2);
    end
  end

  // Start/busy/done follow the current state; flush only takes effect next cycle
  always_comb begin
    md_start_e = 1'b0; busy_stall_d = 1'b0; md_done_e = 1'b0;
    case (state_r)
      IDLE: begin
        if (md_act_s) begin
          md_start_e   = 1'b1;
          busy_stall_d = lat_gt1_s;
          md_done_e    = ~lat_gt1_s;
        end else begin
          md_start_e = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_r != '0) busy_stall_d = 1'b1;
        else             md_done_e = 1'b1;
      end
      default: md_start_e = 1'b0;
    endcase
  end

  // Mul/div occupancy sequencer
  always_ff @(posedge clk) begin
    if (rst | flush_e) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (md_act_s && lat_gt1_s) begin
            state_r <= BUSY;
            cnt_r   <= lat_m2_s;
          end else if (md_act_s && stall_e) begin
            state_r <= HOLD;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != '0) cnt_r   <= cnt_r - CNT_W'(1);
          else if (stall_e) state_r <= HOLD;
          else              state_r <= IDLE;
        end
        HOLD: begin
          if (!stall_e) state_r <= IDLE;
          else          state_r <= HOLD;
        end
        default: state_r <= IDLE;
      endcase
    end
  end
`else
  logic unused_s;
  assign unused_s     = funct7b0 ^ md_s ^ md_e_r ^ div_e_r;
  assign busy_stall_d = 1'b0;
  assign md_start_e   = 1'b0;
  assign md_done_e    = 1'b0;
`endif

endmodule
